imem_uart_loader: RTL and testbench



---
 rtl/imem_uart_loader.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_uart_loader
// Purpose  : Receives a program over an 8N1 UART link and writes it, one
//            32-bit word at a time, into the instruction-memory write port.
//            Holds the core in reset for as long as a load is in progress.
// Revision : 1.0 - initial release
//
// Frame    : 0xA5, N[7:0], N[15:8], then 4*N data bytes (little-endian words)
//            [, checksum byte = XOR of all data bytes]
//
// Ports    : clk         system clock
//            rst_n       asynchronous active-low reset
//            uart_rx     serial input, idle high, asynchronous
//            load_en     load request level from a switch, asynchronous
//            imem_we     one-cycle write strobe
//            imem_waddr  word address of the current write
//            imem_wdata  word being written
//            core_rst_n  core reset, low whenever the loader is not idle
//            busy        high in any state other than IDLE
//            word_count  words written in the current or last load
//            err         sticky error flag, cleared when a new load starts
//
// Option   : define IMEM_LOADER_CHECKSUM_EN to add a trailing checksum byte
//            check (CHK state) after the last data word.
// ============================================================================
module imem_uart_loader #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              load_en,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              err
);

  localparam int unsigned c_div   = CLK_FREQ / BAUD;
  localparam int unsigned c_cnt_w = (c_div > 2) ? $clog2(c_div) : 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(c_div - 1);
  localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(c_div / 2 - 1);
  localparam logic [16:0] c_max = 17'(MAX_WORDS);
  localparam logic [7:0]  c_hdr = 8'hA5;

  // --------------------------------------------------------------------------
  // Input synchronisers and edge-detect history
  // --------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic le_meta_q, le_sync_q, le_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      le_meta_q <= 1'b0;
      le_sync_q <= 1'b0;
      le_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      le_meta_q <= load_en;
      le_sync_q <= le_meta_q;
      le_prev_q <= le_sync_q;
    end
  end

  // --------------------------------------------------------------------------
  // UART receiver
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t          rx_state_q, rx_state_d;
  logic [c_cnt_w-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]         rx_bit_q, rx_bit_d;
  logic [7:0]         rx_shift_q, rx_shift_d;
  logic               byte_valid_q, byte_valid_d;
  logic               frame_err_q, frame_err_d;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Mid-start-bit recheck: a line that is high again was only a glitch.
        if (rx_cnt_q == c_half) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == c_full) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == c_full) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) byte_valid_d = 1'b1;
          else           frame_err_d  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // The shift register holds the received byte until the next frame's data.
  logic [7:0] w_byte;
  assign w_byte = rx_shift_q;

  // --------------------------------------------------------------------------
  // Load FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  // Where the FSM goes once the payload is complete (or N is zero).
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t c_after_data = S_CHK;
`else
  localparam state_t c_after_data = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              busy_q, busy_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [15:0] w_len_new;
  logic        w_last_word;

  assign w_len_new   = {w_byte, len_q[7:0]};
  assign w_last_word = ((17'(count_q) + 17'd1) == {1'b0, len_q});

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    count_d      = count_q;
    err_d        = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    // Address and count advance in the cycle after each write strobe.
    if (we_q) begin
      waddr_d = waddr_q + 1'b1;
      count_d = count_q + 1'b1;
    end

    if (state_q == S_IDLE) begin
      if (le_sync_q && !le_prev_q) begin
        state_d = S_HDR;
        err_d   = 1'b0;
        count_d = '0;
        waddr_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = '0;
`endif
      end
    end else if (!le_sync_q) begin
      // Load request withdrawn: abort, or normal exit from DONE/ERR.
      state_d = S_IDLE;
    end else if (frame_err_q) begin
      state_d = S_ERR;
    end else if (byte_valid_q) begin
      case (state_q)
        S_HDR: if (w_byte == c_hdr) state_d = S_LEN_LO;
        S_LEN_LO: begin
          len_d[7:0] = w_byte;
          state_d    = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d[15:8] = w_byte;
          byte_idx_d  = '0;
          if (w_len_new == 16'd0)                  state_d = c_after_data;
          else if ({1'b0, w_len_new} > c_max)      state_d = S_ERR;
          else                                     state_d = S_DATA;
        end
        S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ w_byte;
`endif
          byte_idx_d = byte_idx_q + 1'b1;
          case (byte_idx_q)
            2'd0:    asm_d[7:0]   = w_byte;
            2'd1:    asm_d[15:8]  = w_byte;
            2'd2:    asm_d[23:16] = w_byte;
            default: begin
              we_d    = 1'b1;
              wdata_d = {w_byte, asm_q};
              if (w_last_word) state_d = c_after_data;
            end
          endcase
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: state_d = (w_byte == csum_q) ? S_DONE : S_ERR;
`endif
        default: ;
      endcase
    end

    if (state_d == S_ERR) err_d = 1'b1;

    core_rst_n_d = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      count_q      <= count_d;
      err_q        <= err_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign word_count = count_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_uart_loader
// Purpose  : Directed self-checking bench for imem_uart_loader with
//            CLK_FREQ=1 MHz, BAUD=100 kbaud (10 clocks per bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_uart_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              uart_rx = 1'b1;
  logic              load_en = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic [ADDR_W:0]   word_count;
  logic              err;

  imem_uart_loader #(
    .CLK_FREQ (1000000),
    .BAUD     (100000),
    .ADDR_W   (ADDR_W),
    .MAX_WORDS(1024)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .load_en   (load_en),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .word_count(word_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write-port monitor: logs every strobe and counts strobes wider than 1 cycle.
  int          nw = 0;
  int          we_long = 0;
  logic        prev_we = 1'b0;
  logic [31:0] wr_data [0:15];
  logic [31:0] wr_addr [0:15];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (nw < 16) begin
        wr_data[nw] = imem_wdata;
        wr_addr[nw] = 32'(imem_waddr);
      end
      nw++;
      if (prev_we) we_long++;
    end
    prev_we = (imem_we === 1'b1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    cycles(10);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cycles(10);
    end
    uart_rx = stop;
    cycles(10);
    uart_rx = 1'b1;
    cycles(4);
  endtask

  logic [7:0] tx_q[$];

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
  endtask

  initial begin
    // ---------------- 1. reset then idle ----------------
    cycles(3);
    check_eq("rst_we",     32'(imem_we),    32'd0);
    check_eq("rst_waddr",  32'(imem_waddr), 32'd0);
    check_eq("rst_wdata",  imem_wdata,      32'd0);
    check_eq("rst_corern", 32'(core_rst_n), 32'd0);
    check_eq("rst_busy",   32'(busy),       32'd0);
    check_eq("rst_wcount", 32'(word_count), 32'd0);
    check_eq("rst_err",    32'(err),        32'd0);
    rst_n = 1'b1;
    cycles(1);
    check_eq("idle_corern", 32'(core_rst_n), 32'd1);
    check_eq("idle_busy",   32'(busy),       32'd0);
    cycles(5);

    // ---------------- 2. normal two-word load ----------------
    load_en = 1'b1;
    cycles(3);
    check_eq("load_corern_low", 32'(core_rst_n), 32'd0);
    check_eq("load_busy",       32'(busy),       32'd1);
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
    send_q();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h70, 1'b1);
`endif
    cycles(3);
    check_eq("n2_nwrites", 32'(nw),  32'd2);
    check_eq("n2_addr0",   wr_addr[0], 32'd0);
    check_eq("n2_data0",   wr_data[0], 32'h00A00513);
    check_eq("n2_addr1",   wr_addr[1], 32'd1);
    check_eq("n2_data1",   wr_data[1], 32'h00500593);
    check_eq("n2_we_width", 32'(we_long), 32'd0);
    check_eq("n2_wcount",  32'(word_count), 32'd2);
    check_eq("n2_waddr",   32'(imem_waddr), 32'd2);
    check_eq("n2_done_busy",   32'(busy),       32'd1);
    check_eq("n2_done_err",    32'(err),        32'd0);
    check_eq("n2_done_corern", 32'(core_rst_n), 32'd0);
    load_en = 1'b0;
    cycles(5);
    check_eq("n2_rel_corern", 32'(core_rst_n), 32'd1);
    check_eq("n2_rel_busy",   32'(busy),       32'd0);
    check_eq("n2_rel_wcount", 32'(word_count), 32'd2);

    // ---------------- 3. glitch, junk bytes, N=1 ----------------
    load_en = 1'b1;
    cycles(5);
    uart_rx = 1'b0;
    cycles(3);
    uart_rx = 1'b1;
    cycles(3);
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_q();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h08, 1'b1);
`endif
    cycles(3);
    check_eq("n1_nwrites", 32'(nw),         32'd3);
    check_eq("n1_addr",    wr_addr[2],      32'd0);
    check_eq("n1_data",    wr_data[2],      32'h12345678);
    check_eq("n1_wcount",  32'(word_count), 32'd1);
    check_eq("n1_err",     32'(err),        32'd0);
    check_eq("n1_we_width", 32'(we_long),   32'd0);
    load_en = 1'b0;
    cycles(5);

    // ---------------- 4. framing error on 2nd data byte ----------------
    load_en = 1'b1;
    cycles(5);
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11};
    send_q();
    send_byte(8'h22, 1'b0);
    cycles(3);
    check_eq("fe_err",     32'(err),        32'd1);
    check_eq("fe_nwrites", 32'(nw),         32'd3);
    check_eq("fe_busy",    32'(busy),       32'd1);
    check_eq("fe_corern",  32'(core_rst_n), 32'd0);
    load_en = 1'b0;
    cycles(5);
    check_eq("fe_sticky_err", 32'(err),  32'd1);
    check_eq("fe_idle_busy",  32'(busy), 32'd0);
    load_en = 1'b1;
    cycles(5);
    check_eq("fe_err_cleared", 32'(err),        32'd0);
    check_eq("fe_wcount_clr",  32'(word_count), 32'd0);

    // ---------------- 5a. oversize N = 0x0401 ----------------
    tx_q = '{8'hA5, 8'h01, 8'h04};
    send_q();
    cycles(3);
    check_eq("ovr_err",     32'(err),  32'd1);
    check_eq("ovr_busy",    32'(busy), 32'd1);
    check_eq("ovr_nwrites", 32'(nw),   32'd3);
    load_en = 1'b0;
    cycles(5);

    // ---------------- 5b. abort after 6 data bytes ----------------
    load_en = 1'b1;
    cycles(5);
    tx_q = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_q();
    cycles(3);
    check_eq("abt_nwrites", 32'(nw),    32'd4);
    check_eq("abt_data",    wr_data[3], 32'h04030201);
    check_eq("abt_addr",    wr_addr[3], 32'd0);
    load_en = 1'b0;
    cycles(5);
    check_eq("abt_busy",   32'(busy),       32'd0);
    check_eq("abt_corern", 32'(core_rst_n), 32'd1);
    check_eq("abt_wcount", 32'(word_count), 32'd1);
    check_eq("abt_err",    32'(err),        32'd0);

    // ---------------- N = 0 ----------------
    load_en = 1'b1;
    cycles(5);
    tx_q = '{8'hA5, 8'h00, 8'h00};
    send_q();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    cycles(3);
    check_eq("n0_busy",    32'(busy),       32'd1);
    check_eq("n0_err",     32'(err),        32'd0);
    check_eq("n0_wcount",  32'(word_count), 32'd0);
    check_eq("n0_nwrites", 32'(nw),         32'd4);
    load_en = 1'b0;
    cycles(5);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // ---------------- checksum mismatch ----------------
    load_en = 1'b1;
    cycles(5);
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00, 8'h71};
    send_q();
    cycles(3);
    check_eq("cks_bad_err", 32'(err), 32'd1);
    load_en = 1'b0;
    cycles(5);
`endif

    // ---------------- reset asserted mid-load ----------------
    load_en = 1'b1;
    cycles(5);
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hAA};
    send_q();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy",   32'(busy),       32'd0);
    check_eq("mid_rst_corern", 32'(core_rst_n), 32'd0);
    check_eq("mid_rst_wcount", 32'(word_count), 32'd0);
    check_eq("mid_rst_wdata",  imem_wdata,      32'd0);
    cycles(2);
    rst_n = 1'b1;
    load_en = 1'b0;
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
